instr_encoder: RTL and testbench

Assembles RV32I/M instruction words from field-level requests and streams them, with target addresses, toward instruction memory. It is the inverse of the core's instruction decoder: every word it emits decodes back to the requested operation. It sits between the debug/boot-load controller (upstream) and the instruction-ROM write port (downstream). Illegal field combinations are rejected with an error code instead of being emitted.

---
 rtl/instr_encoder_pkg.sv | 74 +++++++
 rtl/instr_encoder_if.sv | 41 ++++
 rtl/instr_imm_chk.sv | 65 ++++++
 rtl/instr_encoder.sv | 195 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared types and constants for the RV32I/M instruction encoder
// Purpose: format codes, error codes, opcode constants, FSM state type and the
//          funct3 legality helper shared by the encoder files.
// Ports:   none (package).
package instr_encoder_pkg;

    localparam int ENC_MXLEN = 32;

    // Request format codes carried on req_fmt; 6 and 7 are invalid.
    typedef enum logic [2:0] {
        FMT_R      = 3'd0,
        FMT_LOAD   = 3'd1,
        FMT_OPIMM  = 3'd2,
        FMT_STORE  = 3'd3,
        FMT_BRANCH = 3'd4,
        FMT_SYS    = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_FMT    = 2'd0,
        ERR_FUNCT3 = 2'd1,
        ERR_IMM    = 2'd2,
        ERR_FUNCT7 = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Opcodes shared with the core's decoder.
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MEXT = 7'h01;

    // SYS funct3 0 selectors (the imm field picks the privileged instruction).
    localparam logic [11:0] SYS_ECALL = 12'h000;
    localparam logic [11:0] SYS_MRET  = 12'h302;

    // Register-side fields of a captured request.
    typedef struct packed {
        logic [2:0] fmt;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } req_fields_t;

    // funct3 legality by format. SYS funct3 0 additionally depends on the
    // selector value, which the caller checks separately.
    function automatic logic funct3_legal(input logic [2:0] fmt, input logic [2:0] f3);
        logic ok;
        ok = 1'b1;
        case (fmt)
            FMT_LOAD:   ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            FMT_STORE:  ok = (f3 <= 3'd2);
            FMT_BRANCH: ok = (f3 != 3'd2) && (f3 != 3'd3);
            FMT_SYS:    ok = (f3 != 3'd4);
            default:    ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/response bundle of the instruction encoder
// Purpose: groups the upstream request handshake, the downstream word stream
//          and the error pulse into one interface.
// Ports:   slave  - encoder side (consumes req_*, addr_clr, out_ready)
//          master - controller/ROM side (drives req_*, addr_clr, out_ready)
interface instr_encoder_if
    import instr_encoder_pkg::*;
#(
    parameter int MXLEN = ENC_MXLEN
) ();

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_fmt;
    logic [2:0]       req_funct3;
    logic [6:0]       req_funct7;
    logic [4:0]       req_rd;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [MXLEN-1:0] req_imm;
    logic             addr_clr;
    logic             out_valid;
    logic             out_ready;
    logic [MXLEN-1:0] out_instr;
    logic [MXLEN-1:0] out_addr;
    logic             err;
    logic [1:0]       err_code;

    modport slave (
        input  req_valid, req_fmt, req_funct3, req_funct7, req_rd, req_rs1,
               req_rs2, req_imm, addr_clr, out_ready,
        output req_ready, out_valid, out_instr, out_addr, err, err_code
    );

    modport master (
        output req_valid, req_fmt, req_funct3, req_funct7, req_rd, req_rs1,
               req_rs2, req_imm, addr_clr, out_ready,
        input  req_ready, out_valid, out_instr, out_addr, err, err_code
    );

endinterface

// File: rtl/instr_imm_chk.sv
// rtl/instr_imm_chk.sv - combinational immediate range check and bit slicing
// Purpose: decides whether the immediate fits the requested format and returns
//          the immediate bit slices placed by each instruction format.
// Ports:   i_fmt, i_funct3, i_imm   - captured request fields
//          o_in_range               - immediate legal for this fmt/funct3
//          o_i_imm                  - bits [31:20] for I-type, CSR and shifts
//          o_s_hi / o_s_lo          - S-type bits [31:25] / [11:7]
//          o_b_hi / o_b_lo          - B-type bits [31:25] / [11:7]
module instr_imm_chk
    import instr_encoder_pkg::*;
#(
    parameter int MXLEN = ENC_MXLEN
) (
    input  logic [2:0]       i_fmt,
    input  logic [2:0]       i_funct3,
    input  logic [MXLEN-1:0] i_imm,
    output logic             o_in_range,
    output logic [11:0]      o_i_imm,
    output logic [6:0]       o_s_hi,
    output logic [4:0]       o_s_lo,
    output logic [6:0]       o_b_hi,
    output logic [4:0]       o_b_lo
);

    localparam logic signed [MXLEN-1:0] I_MIN = -MXLEN'(2048);
    localparam logic signed [MXLEN-1:0] I_MAX = MXLEN'(2047);
    localparam logic signed [MXLEN-1:0] B_MIN = -MXLEN'(4096);
    localparam logic signed [MXLEN-1:0] B_MAX = MXLEN'(4094);

    logic signed [MXLEN-1:0] w_simm;
    logic                    w_fits_i;
    logic                    w_fits_b;
    logic                    w_fits_sh;
    logic                    w_fits_csr;
    logic                    w_is_shift;

    assign w_simm     = $signed(i_imm);
    assign w_fits_i   = (w_simm >= I_MIN) && (w_simm <= I_MAX);
    // Branch offsets are in halfwords, so bit 0 must be clear.
    assign w_fits_b   = (w_simm >= B_MIN) && (w_simm <= B_MAX) && !i_imm[0];
    // Shift amount and CSR address are unsigned: negative values fail here.
    assign w_fits_sh  = (i_imm < MXLEN'(32));
    assign w_fits_csr = (i_imm < MXLEN'(4096));
    assign w_is_shift = (i_funct3 == 3'd1) || (i_funct3 == 3'd5);

    always_comb begin
        o_in_range = 1'b1;
        case (i_fmt)
            FMT_LOAD,
            FMT_STORE:  o_in_range = w_fits_i;
            FMT_OPIMM:  o_in_range = w_is_shift ? w_fits_sh : w_fits_i;
            FMT_BRANCH: o_in_range = w_fits_b;
            // funct3 0 uses imm as an ECALL/MRET selector, validated elsewhere.
            FMT_SYS:    o_in_range = (i_funct3 == 3'd0) ? 1'b1 : w_fits_csr;
            default:    o_in_range = 1'b1;
        endcase
    end

    assign o_i_imm = ((i_fmt == FMT_OPIMM) && w_is_shift) ? {7'd0, i_imm[4:0]} : i_imm[11:0];
    assign o_s_hi  = i_imm[11:5];
    assign o_s_lo  = i_imm[4:0];
    assign o_b_hi  = {i_imm[12], i_imm[10:5]};
    assign o_b_lo  = {i_imm[4:1], i_imm[11]};

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I/M instruction word encoder with address stream
// Purpose: captures a field-level request, checks legality, assembles the
//          instruction word and presents it with its write address; illegal
//          requests produce a one-cycle error pulse instead.
// Ports:   clk, rst_n        - clock, asynchronous active-low reset
//          bus (slave)       - req_* handshake, addr_clr, out_* stream, err/err_code
// Config:  INSTR_ENC_MEXT_EN - when defined, R-type funct7 0x01 (M extension) is legal
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int               MXLEN     = ENC_MXLEN,
    parameter logic [MXLEN-1:0] BASE_ADDR = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_encoder_if.slave bus
);

`ifdef INSTR_ENC_MEXT_EN
    localparam logic MEXT_EN = 1'b1;
`else
    localparam logic MEXT_EN = 1'b0;
`endif

    state_e           r_state;
    state_e           w_next_state;
    req_fields_t      r_req;
    logic [MXLEN-1:0] r_imm;
    logic [MXLEN-1:0] r_instr;
    logic [MXLEN-1:0] r_addr;
    err_e             r_err_code;

    logic             w_in_range;
    logic [11:0]      w_i_imm;
    logic [6:0]       w_s_hi;
    logic [4:0]       w_s_lo;
    logic [6:0]       w_b_hi;
    logic [4:0]       w_b_lo;

    logic             w_fmt_ok;
    logic             w_f3_ok;
    logic             w_f7_ok;
    logic             w_sys_sel_ok;
    logic             w_is_shift;
    logic [6:0]       w_sh_f7;
    logic             w_err;
    err_e             w_code;
    logic [31:0]      w_instr;

    instr_imm_chk #(
        .MXLEN      (MXLEN)
    ) u_imm_chk (
        .i_fmt      (r_req.fmt),
        .i_funct3   (r_req.funct3),
        .i_imm      (r_imm),
        .o_in_range (w_in_range),
        .o_i_imm    (w_i_imm),
        .o_s_hi     (w_s_hi),
        .o_s_lo     (w_s_lo),
        .o_b_hi     (w_b_hi),
        .o_b_lo     (w_b_lo)
    );

    // Legality terms, evaluated on the captured request during ENC.
    assign w_fmt_ok     = (r_req.fmt <= FMT_SYS);
    assign w_sys_sel_ok = (r_imm == MXLEN'(SYS_ECALL)) || (r_imm == MXLEN'(SYS_MRET));
    // An unknown SYS funct3 0 selector is reported as a funct3 error.
    assign w_f3_ok      = funct3_legal(r_req.fmt, r_req.funct3) &&
                          !((r_req.fmt == FMT_SYS) && (r_req.funct3 == 3'd0) && !w_sys_sel_ok);
    assign w_f7_ok      = (r_req.funct7 == F7_BASE) ||
                          ((r_req.funct7 == F7_ALT) && ((r_req.funct3 == 3'd0) || (r_req.funct3 == 3'd5))) ||
                          (MEXT_EN && (r_req.funct7 == F7_MEXT));
    assign w_is_shift   = (r_req.funct3 == 3'd1) || (r_req.funct3 == 3'd5);
    // Shift funct7 is not taken from the request: only SRAI gets 0x20.
    assign w_sh_f7      = ((r_req.funct3 == 3'd5) && r_req.funct7[5]) ? F7_ALT : F7_BASE;

    // Error detection in priority order fmt > funct3 > funct7 > immediate.
    always_comb begin
        w_err  = 1'b0;
        w_code = ERR_FMT;
        if (!w_fmt_ok) begin
            w_err  = 1'b1;
            w_code = ERR_FMT;
        end else if (!w_f3_ok) begin
            w_err  = 1'b1;
            w_code = ERR_FUNCT3;
        end else if ((r_req.fmt == FMT_R) && !w_f7_ok) begin
            w_err  = 1'b1;
            w_code = ERR_FUNCT7;
        end else if (!w_in_range) begin
            w_err  = 1'b1;
            w_code = ERR_IMM;
        end
    end

    // Word assembly; only used when no error is flagged.
    always_comb begin
        w_instr = '0;
        case (r_req.fmt)
            FMT_R:
                w_instr = {r_req.funct7, r_req.rs2, r_req.rs1, r_req.funct3, r_req.rd, OPC_OP};
            FMT_LOAD:
                w_instr = {w_i_imm, r_req.rs1, r_req.funct3, r_req.rd, OPC_LOAD};
            FMT_OPIMM:
                if (w_is_shift) begin
                    w_instr = {w_sh_f7, w_i_imm[4:0], r_req.rs1, r_req.funct3, r_req.rd, OPC_OPIMM};
                end else begin
                    w_instr = {w_i_imm, r_req.rs1, r_req.funct3, r_req.rd, OPC_OPIMM};
                end
            FMT_STORE:
                w_instr = {w_s_hi, r_req.rs2, r_req.rs1, r_req.funct3, w_s_lo, OPC_STORE};
            FMT_BRANCH:
                w_instr = {w_b_hi, r_req.rs2, r_req.rs1, r_req.funct3, w_b_lo, OPC_BRANCH};
            FMT_SYS:
                if (r_req.funct3 == 3'd0) begin
                    // ECALL/MRET carry no register fields.
                    w_instr = {w_i_imm, 5'd0, 3'd0, 5'd0, OPC_SYSTEM};
                end else begin
                    // CSR*I forms carry zimm in the rs1 slot, so the layout is shared.
                    w_instr = {w_i_imm, r_req.rs1, r_req.funct3, r_req.rd, OPC_SYSTEM};
                end
            default:
                w_instr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.req_valid) w_next_state = ST_ENC;
            ST_ENC:  w_next_state = w_err ? ST_ERR : ST_HOLD;
            ST_HOLD: if (bus.out_ready) w_next_state = ST_IDLE;
            ST_ERR:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req      <= '0;
            r_imm      <= '0;
            r_instr    <= '0;
            r_addr     <= BASE_ADDR;
            r_err_code <= ERR_FMT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.addr_clr) begin
                        r_addr <= BASE_ADDR;
                    end
                    if (bus.req_valid) begin
                        r_req.fmt    <= bus.req_fmt;
                        r_req.funct3 <= bus.req_funct3;
                        r_req.funct7 <= bus.req_funct7;
                        r_req.rd     <= bus.req_rd;
                        r_req.rs1    <= bus.req_rs1;
                        r_req.rs2    <= bus.req_rs2;
                        r_imm        <= bus.req_imm;
                    end
                end
                ST_ENC: begin
                    if (w_err) begin
                        r_err_code <= w_code;
                    end else begin
                        r_instr <= MXLEN'(w_instr);
                    end
                end
                ST_HOLD: begin
                    // Address advances only on a completed handshake; wraps naturally.
                    if (bus.out_ready) begin
                        r_addr <= r_addr + MXLEN'(4);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.err       = (r_state == ST_ERR);
    assign bus.err_code  = r_err_code;
    assign bus.out_instr = r_instr;
    assign bus.out_addr  = r_addr;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0100;

`ifdef INSTR_ENC_MEXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if #(.MXLEN(32)) bus ();

    instr_encoder #(
        .MXLEN     (32),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_addr;
    bit          last_ok;
    logic [31:0] last_word;
    logic [31:0] last_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: builds the word from the ISA field layout with plain arithmetic.
    task automatic model(input logic [31:0] fmt, input logic [31:0] f3, input logic [31:0] f7,
                         input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm,
                         output bit ok, output logic [31:0] code, output logic [31:0] w);
        int          s;
        logic [31:0] u;
        logic [31:0] m;
        logic [31:0] regs;
        s    = $signed(imm);
        u    = imm;
        ok   = 1'b0;
        code = 0;
        w    = 0;
        regs = rs1 * 32768 + f3 * 4096 + rd * 128;
        case (fmt)
            0: if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)) || (M_EN && f7 == 1)) begin
                   ok = 1'b1;
                   w  = f7 * 33554432 + rs2 * 1048576 + regs + 'h33;
               end else code = 3;
            1: if (!(f3 inside {0, 1, 2, 4, 5})) code = 1;
               else if (s < -2048 || s > 2047) code = 2;
               else begin ok = 1'b1; w = (s & 'hFFF) * 1048576 + regs + 'h03; end
            2: if (f3 == 1 || f3 == 5) begin
                   if (u > 31) code = 2;
                   else begin
                       ok = 1'b1;
                       w  = ((f3 == 5 && (f7 / 32) % 2 == 1) ? 32 : 0) * 33554432 + u * 1048576 + regs + 'h13;
                   end
               end else if (s < -2048 || s > 2047) code = 2;
               else begin ok = 1'b1; w = (s & 'hFFF) * 1048576 + regs + 'h13; end
            3: if (f3 > 2) code = 1;
               else if (s < -2048 || s > 2047) code = 2;
               else begin
                   ok = 1'b1;
                   m  = s & 'hFFF;
                   w  = (m / 32) * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + (m % 32) * 128 + 'h23;
               end
            4: if (f3 == 2 || f3 == 3) code = 1;
               else if (s % 2 != 0 || s < -4096 || s > 4094) code = 2;
               else begin
                   ok = 1'b1;
                   m  = s & 'h1FFF;
                   w  = ((m / 4096) * 64 + (m / 32) % 64) * 33554432 + rs2 * 1048576 + rs1 * 32768
                        + f3 * 4096 + (((m / 2) % 16) * 2 + (m / 2048) % 2) * 128 + 'h63;
               end
            5: if (f3 == 4) code = 1;
               else if (f3 == 0) begin
                   if (u == 0) begin ok = 1'b1; w = 'h73; end
                   else if (u == 'h302) begin ok = 1'b1; w = 'h3020_0073; end
                   else code = 1;
               end else if (u > 4095) code = 2;
               else begin ok = 1'b1; w = u * 1048576 + regs + 'h73; end
            default: code = 0;
        endcase
    endtask

    // Presents one request at the next edge and checks the ENC cycle and the
    // HOLD/ERR cycle that follows. Leaves the bench at posedge+1 of that cycle.
    task automatic issue(input string tag, input logic [31:0] fmt, input logic [31:0] f3,
                         input logic [31:0] f7, input logic [31:0] rd, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm);
        int n;
        model(fmt, f3, f7, rd, rs1, rs2, imm, last_ok, last_code, last_word);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_fmt    = fmt[2:0];
        bus.req_funct3 = f3[2:0];
        bus.req_funct7 = f7[6:0];
        bus.req_rd     = rd[4:0];
        bus.req_rs1    = rs1[4:0];
        bus.req_rs2    = rs2[4:0];
        bus.req_imm    = imm;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk({tag, "/enc_cycle"}, 32'({bus.out_valid, bus.err, bus.req_ready}), 32'd0);
        @(posedge clk); #1;
        chk({tag, "/valid"}, 32'(bus.out_valid), 32'(last_ok));
        chk({tag, "/err"}, 32'(bus.err), 32'(!last_ok));
        if (last_ok) begin
            chk({tag, "/instr"}, bus.out_instr, last_word);
            chk({tag, "/addr"}, bus.out_addr, exp_addr);
        end else begin
            chk({tag, "/code"}, 32'(bus.err_code), last_code);
        end
    endtask

    task automatic finish_req(input string tag);
        if (last_ok) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            exp_addr = exp_addr + 32'd4;
            chk({tag, "/valid_drop"}, 32'(bus.out_valid), 32'd0);
        end else begin
            @(posedge clk); #1;
            chk({tag, "/err_drop"}, 32'(bus.err), 32'd0);
            chk({tag, "/addr_keep"}, bus.out_addr, exp_addr);
        end
    endtask

    function automatic logic [31:0] pick_imm();
        case ($urandom_range(0, 17))
            0:  return 32'd0;
            1:  return 32'd5;
            2:  return 32'hFFFF_FFFF;
            3:  return 32'hFFFF_F800;
            4:  return 32'd2047;
            5:  return 32'd2048;
            6:  return 32'hFFFF_F7FF;
            7:  return 32'd31;
            8:  return 32'd32;
            9:  return 32'hFFFF_FFFC;
            10: return 32'd4094;
            11: return 32'd4095;
            12: return 32'hFFFF_F000;
            13: return 32'hFFFF_EFFE;
            14: return 32'h0000_0302;
            15: return 32'd4096;
            16: return 32'd3;
            default: return $urandom_range(0, 8191) - 32'd4096;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fmt, f3, f7, rd, rs1, rs2, imm;

        bus.req_valid  = 1'b0;
        bus.req_fmt    = '0;
        bus.req_funct3 = '0;
        bus.req_funct7 = '0;
        bus.req_rd     = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_imm    = '0;
        bus.addr_clr   = 1'b0;
        bus.out_ready  = 1'b0;
        exp_addr       = BASE;

        repeat (2) @(posedge clk);
        #1;
        chk("rst/req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst/out_instr", bus.out_instr, 32'd0);
        chk("rst/out_addr", bus.out_addr, BASE);
        chk("rst/err", 32'(bus.err), 32'd0);
        chk("rst/err_code", 32'(bus.err_code), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // addi x1, x0, 5
        issue("addi", 2, 0, 0, 1, 0, 0, 32'd5);
        chk("addi/lit", bus.out_instr, 32'h0050_0093);
        finish_req("addi");

        // add x3,x1,x2 then sw x2,8(x1)
        issue("add", 0, 0, 0, 3, 1, 2, 32'd0);
        chk("add/lit", bus.out_instr, 32'h0020_81B3);
        finish_req("add");
        issue("sw", 3, 2, 0, 0, 1, 2, 32'd8);
        chk("sw/lit", bus.out_instr, 32'h0020_A423);
        chk("sw/addr_lit", bus.out_addr, BASE + 32'd8);
        finish_req("sw");

        // beq x1,x2,-4 held for 5 cycles; req_valid and addr_clr must be ignored
        issue("beq", 4, 0, 0, 0, 1, 2, 32'hFFFF_FFFC);
        chk("beq/lit", bus.out_instr, 32'hFE20_8EE3);
        bus.req_valid = 1'b1;
        bus.req_fmt   = 3'd2;
        bus.addr_clr  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold/valid", 32'(bus.out_valid), 32'd1);
            chk("hold/instr", bus.out_instr, 32'hFE20_8EE3);
            chk("hold/addr", bus.out_addr, exp_addr);
            chk("hold/req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.req_valid = 1'b0;
        bus.addr_clr  = 1'b0;
        exp_addr = exp_addr + 32'd4;
        @(posedge clk); #1;
        chk("hold/not_consumed", 32'({bus.req_ready, bus.out_valid, bus.err}), 32'b100);
        chk("hold/addr_after", bus.out_addr, exp_addr);

        // mul x5,x6,x7 (M extension)
        issue("mul", 0, 0, 1, 5, 6, 7, 32'd0);
`ifdef INSTR_ENC_MEXT_EN
        chk("mul/lit", bus.out_instr, 32'h0273_02B3);
`else
        chk("mul/code_lit", 32'(bus.err_code), 32'd3);
`endif
        finish_req("mul");

        // addi with imm 2048 is out of range
        issue("imm2048", 2, 0, 0, 1, 0, 0, 32'd2048);
        chk("imm2048/code_lit", 32'(bus.err_code), 32'd2);
        finish_req("imm2048");

        // mret
        issue("mret", 5, 0, 0, 0, 0, 0, 32'h0000_0302);
        chk("mret/lit", bus.out_instr, 32'h3020_0073);
        finish_req("mret");

        // bad fmt takes priority over everything else
        issue("badfmt", 7, 4, 99, 1, 1, 1, 32'd99999);
        chk("badfmt/code_lit", 32'(bus.err_code), 32'd0);
        finish_req("badfmt");

        for (int i = 0; i < 60; i++) begin
            fmt = $urandom_range(0, 7);
            f3  = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0:       f7 = 0;
                1:       f7 = 1;
                2:       f7 = 32;
                default: f7 = $urandom_range(0, 127);
            endcase
            rd  = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            imm = pick_imm();
            issue("rnd", fmt, f3, f7, rd, rs1, rs2, imm);
            finish_req("rnd");
        end

        // addr_clr in IDLE restarts the address stream
        bus.addr_clr = 1'b1;
        @(posedge clk); #1;
        bus.addr_clr = 1'b0;
        exp_addr = BASE;
        chk("clr/addr", bus.out_addr, BASE);
        issue("clr", 1, 2, 0, 4, 5, 0, 32'hFFFF_FFF0);
        chk("clr/addr_lit", bus.out_addr, BASE);
        finish_req("clr");

        // reset during HOLD drops the word at once
        issue("rsthold", 0, 5, 32, 9, 10, 11, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rsthold/valid", 32'(bus.out_valid), 32'd0);
        chk("rsthold/addr", bus.out_addr, BASE);
        chk("rsthold/instr", bus.out_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr = BASE;
        @(posedge clk); #1;
        issue("after_rst", 2, 5, 32, 2, 3, 0, 32'd7);
        finish_req("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
